// File: rtl/axi_read_responder_if.sv
// -----------------------------------------------------------------------------
// axi_read_responder_if
// AXI4 read-channel bundle (AR + R) shared by the read initiator and the
// axi_read_responder subordinate. Clock and reset are not part of the bundle.
//
// Parameters:
//   ADDR_W  address width, also the rdata width
//   ID_W    arid/rid width
//
// Signals:
//   arvalid/arready           AR handshake
//   araddr, arlen, arsize     burst start byte address, beats-1, log2 bytes/beat
//   arid                      transaction ID
//   rvalid/rready             R handshake
//   rdata, rid, rresp, rlast  beat data, echoed ID, response, final-beat flag
//
// Modports:
//   master  initiator side (drives AR and rready)
//   slave   subordinate side (drives arready and R)
// -----------------------------------------------------------------------------
interface axi_read_responder_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) ();
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [ID_W-1:0]   arid;

  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arid, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arid, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi_read_responder.sv
// -----------------------------------------------------------------------------
// axi_read_responder
// AXI4 read-channel subordinate (INCR bursts only). Accepted AR requests are
// queued in acceptance order and answered with R bursts whose data is derived
// from the beat address: OKAY beats return addr ^ DATA_XOR, error bursts
// (too long, or beat size wider than the data bus) return zero data with
// SLVERR for the full arlen+1 beats.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high
//   bus     axi_read_responder_if.slave (AR and R channels)
//   busy    request queue non-empty or a burst in progress
//
// Optional build macro:
//   AXI_RESP_STALL_EN  when defined, a 16-bit LFSR inserts single-cycle
//                      rvalid bubbles between beats of a burst.
//
// States:
//   IDLE  | no burst active, waiting for a queued request
//   BURST | rvalid high, presenting the current beat
//   GAP   | one-cycle rvalid bubble inside a burst (stall build only)
// -----------------------------------------------------------------------------
module axi_read_responder #(
  parameter int              ADDR_W      = 32,
  parameter int              ID_W        = 4,
  parameter int              QUEUE_DEPTH = 4,
  parameter int              MAX_LEN     = 16,
  parameter logic [ADDR_W-1:0] DATA_XOR  = 32'hA5A5_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  axi_read_responder_if.slave    bus,
  output logic                   busy
);

  localparam int PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int SIZE_MAX = $clog2(ADDR_W / 8);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [ID_W-1:0]   id;
    logic              err;
  } req_t;

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  req_t             q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop, adv, stall_hit;
  req_t             req_in, head;

  state_t            state, state_n;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_rem;
  logic [2:0]        b_size;
  logic [ID_W-1:0]   b_id;
  logic              b_err;

  // arready only depends on the queue count, so a pop in the same cycle
  // never reopens a full queue.
  assign full        = (count == (PTR_W+1)'(QUEUE_DEPTH));
  assign empty       = (count == '0);
  assign bus.arready = !full && !reset;
  assign push        = bus.arvalid && bus.arready;
  assign head        = q_mem[rd_ptr];

  always_comb begin
    req_in      = '0;
    req_in.addr = bus.araddr;
    req_in.len  = bus.arlen;
    req_in.size = bus.arsize;
    req_in.id   = bus.arid;
    req_in.err  = (int'(bus.arlen) + 1 > MAX_LEN) || (int'(bus.arsize) > SIZE_MAX);
  end

  always_ff @(posedge clock) begin
    if (push) q_mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

`ifdef AXI_RESP_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall_hit = (lfsr[1:0] == 2'b11);
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    adv     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = BURST;
        end
      end
      BURST: begin
        if (bus.rready) begin
          if (b_rem != 8'd0) begin
            adv = 1'b1;
            if (stall_hit) state_n = GAP;
          end else if (!empty) begin
            // back-to-back bursts: next request loads on the last-beat edge
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP:     state_n = BURST;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      b_addr <= '0;
      b_rem  <= '0;
      b_size <= '0;
      b_id   <= '0;
      b_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (pop) begin
        b_addr <= head.addr;
        b_rem  <= head.len;
        b_size <= head.size;
        b_id   <= head.id;
        b_err  <= head.err;
      end else if (adv) begin
        b_addr <= b_addr + (ADDR_W'(1) << b_size);
        b_rem  <= b_rem - 8'd1;
      end
    end
  end

  // Beat outputs come straight from registers, so they cannot change while
  // a beat waits for rready.
  assign bus.rvalid = (state == BURST);
  assign bus.rlast  = bus.rvalid && (b_rem == 8'd0);
  assign bus.rresp  = (bus.rvalid && b_err) ? 2'b10 : 2'b00;
  assign bus.rdata  = (bus.rvalid && !b_err) ? (b_addr ^ DATA_XOR) : '0;
  assign bus.rid    = b_id;
  assign busy       = !empty || (state != IDLE);

endmodule

// File: tb/tb_axi_read_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_read_responder
// Self-checking bench for axi_read_responder. A reference model turns every
// accepted AR into its list of expected beats (address arithmetic on the
// request fields) and the R channel is compared against the head of that
// list on every cycle rvalid is high.
// -----------------------------------------------------------------------------
module tb_axi_read_responder;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;

  logic clock = 1'b0;
  logic reset;
  logic busy;

  axi_read_responder_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  axi_read_responder #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .QUEUE_DEPTH(4), .MAX_LEN(16),
    .DATA_XOR(32'hA5A5_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       b_m;
  int          n_beats = 0;
  int          n_err_beats = 0;
  logic [31:0] last_rdata = '0;
  bit          exp_rv_set = 0, exp_rv = 0, gap_follow = 0, stall = 0;
  bit          err_m;
  int          lat_stage = 0;

`ifdef AXI_RESP_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clock)
    lfsr_m <= reset ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif

  // rready driver: 0 = low, 1 = high, 2 = pattern 1,0,0,1, other = random
  int rr_mode = 0;
  int rr_cnt  = 0;
  always @(posedge clock) begin
    #1;
    case (rr_mode)
      0: bus.rready = 1'b0;
      1: bus.rready = 1'b1;
      2: begin
        bus.rready = (rr_cnt % 4 == 0) || (rr_cnt % 4 == 3);
        rr_cnt++;
      end
      default: bus.rready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples mid-cycle, i.e. the values the next rising edge will see.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      exp_rv_set = 0;
      gap_follow = 0;
      lat_stage  = 0;
    end else begin
      if (exp_rv_set) chk("rvalid_seq", bus.rvalid, exp_rv);
      exp_rv_set = 0;
      if (gap_follow) begin
        exp_rv_set = 1;
        exp_rv     = 1;
        gap_follow = 0;
      end

      if (lat_stage == 1) begin
        chk("lat_edge_k", bus.rvalid, 1'b0);
        lat_stage = 2;
      end else if (lat_stage == 2) begin
        chk("lat_edge_k1", bus.rvalid, 1'b1);
        lat_stage = 0;
      end

      if (bus.rvalid) begin
        if (exp_q.size() == 0) begin
          chk("stale_rvalid", bus.rvalid, 1'b0);
        end else begin
          chk("rdata", bus.rdata, exp_q[0].data);
          chk("rid",   bus.rid,   exp_q[0].id);
          chk("rresp", bus.rresp, exp_q[0].resp);
          chk("rlast", bus.rlast, exp_q[0].last);
          if (bus.rready) begin
            last_rdata = bus.rdata;
            n_beats++;
            if (bus.rresp == 2'b10) n_err_beats++;
            stall = 0;
`ifdef AXI_RESP_STALL_EN
            stall = !exp_q[0].last && (lfsr_m[1:0] == 2'b11);
`endif
            void'(exp_q.pop_front());
            exp_rv_set = 1;
            exp_rv     = (exp_q.size() != 0) && !stall;
            gap_follow = stall;
          end else begin
            exp_rv_set = 1;
            exp_rv     = 1;
          end
        end
      end

      if (bus.arvalid && bus.arready) begin
        if (exp_q.size() == 0) lat_stage = 1;
        err_m = (int'(bus.arlen) + 1 > 16) || (bus.arsize > 3'd2);
        for (int i = 0; i <= int'(bus.arlen); i++) begin
          b_m.data = err_m ? 32'h0
                   : ((bus.araddr + 32'(i) * (32'd1 << bus.arsize)) ^ 32'hA5A5_0000);
          b_m.id   = bus.arid;
          b_m.resp = err_m ? 2'b10 : 2'b00;
          b_m.last = (i == int'(bus.arlen));
          exp_q.push_back(b_m);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [3:0] id, output int waited);
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arid    = id;
    waited      = 0;
    @(negedge clock);
    while (!bus.arready && waited < 4000) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.arready) chk("ar_accept_timeout", bus.arready, 1'b1);
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (busy || exp_q.size() != 0) chk("drain_timeout", busy, 1'b0);
    @(posedge clock); #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nb0, ne0;
    reset = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arid = '0;
    rr_mode = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_rvalid",  bus.rvalid,  1'b0);
    chk("rst_rlast",   bus.rlast,   1'b0);
    chk("rst_rresp",   bus.rresp,   2'b00);
    chk("rst_rdata",   bus.rdata,   32'h0);
    chk("rst_rid",     bus.rid,     4'h0);
    chk("rst_busy",    busy,        1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rel_arready", bus.arready, 1'b1);
    @(posedge clock); #1;

    // single burst
    rr_mode = 1; nb0 = n_beats;
    ar_send(32'h1000, 8'd1, 3'd2, 4'd3, w);
    wait_idle();
    chk("single_beats", n_beats - nb0, 2);

    // queue full: 5 accepted with rready low, 6th stalls
    rr_mode = 0; nb0 = n_beats;
    for (int i = 0; i < 5; i++) begin
      ar_send(32'h2000 + 32'(i) * 32'h100, 8'd1, 3'd2, 4'(i + 1), w);
      chk("qfull_push_wait", w, 0);
    end
    bus.arvalid = 1'b1; bus.araddr = 32'h2500; bus.arlen = 8'd1; bus.arsize = 3'd2; bus.arid = 4'd6;
    repeat (3) begin
      @(negedge clock);
      chk("qfull_arready", bus.arready, 1'b0);
      chk("qfull_busy", busy, 1'b1);
    end
    @(posedge clock); #1;
    rr_mode = 1;
    ar_send(32'h2500, 8'd1, 3'd2, 4'd6, w);
    wait_idle();
    chk("qfull_beats", n_beats - nb0, 12);

    // backpressure pattern 1,0,0,1
    rr_mode = 2; nb0 = n_beats;
    ar_send(32'h4000, 8'd7, 3'd2, 4'd5, w);
    ar_send(32'h5000, 8'd3, 3'd1, 4'd6, w);
    wait_idle();
    chk("bp_beats", n_beats - nb0, 12);

    // error bursts and MAX_LEN boundary
    rr_mode = 3; nb0 = n_beats; ne0 = n_err_beats;
    ar_send(32'h36f8fe20, 8'd255, 3'd2, 4'd9, w);
    ar_send(32'h8000, 8'd3, 3'd2, 4'd10, w);
    wait_idle();
    chk("err255_err_beats", n_err_beats - ne0, 256);
    chk("err255_total", n_beats - nb0, 260);
    nb0 = n_beats; ne0 = n_err_beats;
    ar_send(32'h9000, 8'd0, 3'd3, 4'd11, w);
    ar_send(32'h9100, 8'd16, 3'd2, 4'd12, w);
    ar_send(32'h9200, 8'd15, 3'd2, 4'd13, w);
    wait_idle();
    chk("bound_err_beats", n_err_beats - ne0, 18);
    chk("bound_total", n_beats - nb0, 34);

    // 16-beat burst, rready high
    rr_mode = 1; nb0 = n_beats;
    ar_send(32'hC000, 8'd15, 3'd2, 4'd12, w);
    wait_idle();
    chk("len16_beats", n_beats - nb0, 16);

    // randomized traffic
    rr_mode = 3;
    for (int i = 0; i < 40; i++) begin
      ar_send($urandom, 8'($urandom_range(0, 20)), 3'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), w);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    wait_idle();

    // address wrap
    rr_mode = 1; nb0 = n_beats;
    ar_send(32'hFFFF_FFFC, 8'd1, 3'd2, 4'd7, w);
    wait_idle();
    chk("wrap_beats", n_beats - nb0, 2);
    chk("wrap_beat2", last_rdata, 32'hA5A5_0000);

    // reset mid-burst with two requests queued
    rr_mode = 0;
    ar_send(32'hA000, 8'd7, 3'd2, 4'd1, w);
    ar_send(32'hB000, 8'd3, 3'd2, 4'd2, w);
    ar_send(32'hB100, 8'd3, 3'd2, 4'd3, w);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("mrst_rvalid",  bus.rvalid,  1'b0);
    chk("mrst_busy",    busy,        1'b0);
    chk("mrst_arready", bus.arready, 1'b0);
    chk("mrst_rlast",   bus.rlast,   1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    rr_mode = 1; nb0 = n_beats;
    @(negedge clock);
    chk("mrst_rel_arready", bus.arready, 1'b1);
    repeat (20) @(negedge clock);
    chk("mrst_no_beats", n_beats - nb0, 0);
    chk("mrst_busy_after", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
